// File: rtl/reg_file_rw.sv
// Integer register file: one write port, two registered read ports, self-clear after reset.
// Define RF_BYPASS_EN for write-first same-cycle forwarding; otherwise reads are read-first.
package core;
    localparam int XLEN      = 32;
    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = $clog2(NUM_REGS);

    typedef struct packed {
        logic                 en;
        logic [REG_IDX_W-1:0] rd_num;
        logic [XLEN-1:0]      rd_value;
    } rf_write_req_t;
endpackage

module reg_file_rw #(
    parameter int XLEN     = core::XLEN,
    parameter int NUM_REGS = core::NUM_REGS,
    localparam int IDX_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  core::rf_write_req_t rf_write_req,
    input  logic                rs1_en,
    input  logic [IDX_W-1:0]    rs1_num,
    input  logic                rs2_en,
    input  logic [IDX_W-1:0]    rs2_num,
    output logic [XLEN-1:0]     rs1_value,
    output logic [XLEN-1:0]     rs2_value,
    output logic                rdy
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state, next_state;
    logic [IDX_W-1:0]  clr_idx;
    logic [XLEN-1:0]   regs [1:NUM_REGS-1];

    logic              clr_last;
    logic              wr_fire;
    logic              rd1_fire, rd2_fire;
    logic [XLEN-1:0]   rd1_data, rd2_data;

    assign clr_last = (clr_idx == IDX_W'(NUM_REGS - 1));
    assign wr_fire  = (state == READY) && en && rf_write_req.en && (rf_write_req.rd_num != '0);
    assign rd1_fire = (state == READY) && en && rs1_en;
    assign rd2_fire = (state == READY) && en && rs2_en;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (clr_last) next_state = READY;
            READY:   next_state = READY;
            default: next_state = CLEAR;
        endcase
    end

    always_comb begin
        rd1_data = '0;
        rd2_data = '0;
        if (rs1_num != '0) begin
            rd1_data = regs[rs1_num];
`ifdef RF_BYPASS_EN
            if (wr_fire && (rf_write_req.rd_num == rs1_num)) rd1_data = rf_write_req.rd_value;
`endif
        end
        if (rs2_num != '0) begin
            rd2_data = regs[rs2_num];
`ifdef RF_BYPASS_EN
            if (wr_fire && (rf_write_req.rd_num == rs2_num)) rd2_data = rf_write_req.rd_value;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= CLEAR;
            clr_idx   <= IDX_W'(1);
            rdy       <= 1'b0;
            rs1_value <= '0;
            rs2_value <= '0;
        end else begin
            state <= next_state;
            rdy   <= (next_state == READY);
            if (state == CLEAR) clr_idx <= clr_idx + IDX_W'(1);
            if (rd1_fire) rs1_value <= rd1_data;
            if (rd2_fire) rs2_value <= rd2_data;
        end
    end

    // NOTE: the storage array has no reset branch; it is zeroed by the clear sequence instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == CLEAR) begin
                regs[clr_idx] <= '0;
            end else if (wr_fire) begin
                regs[rf_write_req.rd_num] <= rf_write_req.rd_value;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_rw.sv
// Directed self-checking bench for reg_file_rw; expectation of the same-cycle hazard follows RF_BYPASS_EN.
module tb_reg_file_rw;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    core::rf_write_req_t wr;
    logic                rs1_en, rs2_en;
    logic [4:0]          rs1_num, rs2_num;
    logic [31:0]         rs1_value, rs2_value;
    logic                rdy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    reg_file_rw dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .rf_write_req (wr),
        .rs1_en       (rs1_en),
        .rs1_num      (rs1_num),
        .rs2_en       (rs2_en),
        .rs2_num      (rs2_num),
        .rs1_value    (rs1_value),
        .rs2_value    (rs2_value),
        .rdy          (rdy)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the falling edge after a rising edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr.en       = 1'b0;
        wr.rd_num   = '0;
        wr.rd_value = '0;
        rs1_en      = 1'b0;
        rs2_en      = 1'b0;
        rs1_num     = '0;
        rs2_num     = '0;
    endtask

    task automatic clear_sequence(input string tag);
        for (int i = 1; i <= 31; i++) begin
            cycle();
            check($sformatf("%s_rdy_edge%0d", tag, i), {31'b0, rdy}, (i == 31) ? 32'd1 : 32'd0);
        end
    endtask

    logic [31:0] hazard_exp;

    initial begin
        rst = 1'b0;
        en  = 1'b1;
        idle_inputs();

        // Reset held for 3 cycles, then full clear.
        @(negedge clk);
        repeat (3) cycle();
        check("reset_rdy", {31'b0, rdy}, 32'd0);
        check("reset_rs1", rs1_value, 32'd0);
        check("reset_rs2", rs2_value, 32'd0);
        rst = 1'b1;
        clear_sequence("clear");

        // Every architectural register reads back zero.
        rs1_en = 1'b1;
        rs2_en = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            rs1_num = 5'(i);
            rs2_num = 5'(32 - i);
            cycle();
            check($sformatf("zero_rs1_x%0d", i), rs1_value, 32'd0);
            check($sformatf("zero_rs2_x%0d", 32 - i), rs2_value, 32'd0);
        end
        idle_inputs();

        // Write x5, read it on both ports the next cycle.
        wr.en = 1'b1; wr.rd_num = 5'd5; wr.rd_value = 32'hDEADBEEF;
        cycle();
        idle_inputs();
        rs1_en = 1'b1; rs1_num = 5'd5;
        rs2_en = 1'b1; rs2_num = 5'd5;
        cycle();
        check("wr_x5_rs1", rs1_value, 32'hDEADBEEF);
        check("wr_x5_rs2", rs2_value, 32'hDEADBEEF);

        // x0: same-cycle write and read never bypass, then a plain read.
        wr.en = 1'b1; wr.rd_num = 5'd0; wr.rd_value = 32'hFFFFFFFF;
        rs1_num = 5'd0; rs2_num = 5'd0;
        cycle();
        check("x0_same_rs1", rs1_value, 32'd0);
        check("x0_same_rs2", rs2_value, 32'd0);
        wr.en = 1'b0;
        cycle();
        check("x0_rs1", rs1_value, 32'd0);
        check("x0_rs2", rs2_value, 32'd0);
        idle_inputs();

        // Same-cycle write/read hazard on x7.
        wr.en = 1'b1; wr.rd_num = 5'd7; wr.rd_value = 32'h11111111;
        cycle();
        wr.rd_value = 32'h22222222;
        rs1_en = 1'b1; rs1_num = 5'd7;
        cycle();
`ifdef RF_BYPASS_EN
        hazard_exp = 32'h22222222;
`else
        hazard_exp = 32'h11111111;
`endif
        check("hazard_same_cycle", rs1_value, hazard_exp);
        wr.en = 1'b0;
        cycle();
        check("hazard_next_read", rs1_value, 32'h22222222);
        idle_inputs();

        // Enable low: reads hold and writes are ignored.
        wr.en = 1'b1; wr.rd_num = 5'd8; wr.rd_value = 32'h0000000A;
        cycle();
        wr.en = 1'b0;
        rs1_en = 1'b1; rs1_num = 5'd8;
        cycle();
        check("en_setup_rs1", rs1_value, 32'h0000000A);
        en = 1'b0;
        rs1_num = 5'd9;
        wr.en = 1'b1; wr.rd_num = 5'd9; wr.rd_value = 32'h00000005;
        cycle();
        check("en_low_hold_rs1", rs1_value, 32'h0000000A);
        check("en_low_rdy", {31'b0, rdy}, 32'd1);
        en = 1'b1;
        wr.en = 1'b0;
        cycle();
        check("en_low_no_write_x9", rs1_value, 32'd0);
        idle_inputs();

        // Reset from READY, then a second reset at clear edge 10.
        rst = 1'b0;
        cycle();
        check("rst2_rdy", {31'b0, rdy}, 32'd0);
        check("rst2_rs1", rs1_value, 32'd0);
        rst = 1'b1;
        repeat (10) cycle();
        check("midclr_rdy_edge10", {31'b0, rdy}, 32'd0);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        // A write held through the whole clear must be dropped.
        wr.en = 1'b1; wr.rd_num = 5'd3; wr.rd_value = 32'h33333333;
        clear_sequence("midclr");
        idle_inputs();

        rs1_en = 1'b1; rs2_en = 1'b1;
        rs1_num = 5'd5; rs2_num = 5'd7;
        cycle();
        check("midclr_x5", rs1_value, 32'd0);
        check("midclr_x7", rs2_value, 32'd0);
        rs1_num = 5'd8; rs2_num = 5'd3;
        cycle();
        check("midclr_x8", rs1_value, 32'd0);
        check("midclr_write_dropped_x3", rs2_value, 32'd0);
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
